// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg : seven-segment constants and frame types shared with the encoder
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000011;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [3:0] DIG_INVALID = 4'hF;

  typedef logic [27:0] seg_frame_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] err;
  } disp_frame_t;

endpackage

`default_nettype wire

// File: rtl/seg7_to_bcd.sv
// ---------------------------------------------------------------------------
// seg7_to_bcd : exact-match seven-segment pattern to BCD digit decoder
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       invalid
);

  always_comb begin
    digit   = DIG_INVALID;
    invalid = 1'b0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: invalid = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hexdisp_reader.sv
// ---------------------------------------------------------------------------
// hexdisp_reader : debounce four HEX buses, decode to two binary pairs, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hexdisp_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLK50,
  input  logic       RST,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX2,
  input  logic [6:0] HEX3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_hi,
  output logic [7:0] out_lo,
  output logic [3:0] out_err,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  seg_frame_t  hex_in;
  seg_frame_t  s_q, snap_q, snap_d;
  logic [7:0]  cnt_q, cnt_d;
  disp_frame_t out_q, out_d, pend_q, pend_d, new_frame;
  logic        out_valid_q, out_valid_d, pend_valid_q, pend_valid_d;
  logic [7:0]  drop_q, drop_d;
  logic        accept, handshake;

  logic [3:0] dig [4];
  logic [3:0] inv;

  assign hex_in = {HEX3, HEX2, HEX1, HEX0};

  for (genvar i = 0; i < 4; i++) begin : g_dec
    seg7_to_bcd u_dec (
      .seg     (s_q[7*i +: 7]),
      .digit   (dig[i]),
      .invalid (inv[i])
    );
  end

  function automatic logic [7:0] pair_to_bin(input logic [3:0] dh, input logic [3:0] dl,
                                             input logic bad);
    logic [7:0] v;
    v = {4'd0, dh} * 8'd10 + {4'd0, dl};
    return bad ? 8'hFF : v;
  endfunction

  always_comb begin
    new_frame.hi  = pair_to_bin(dig[3], dig[2], inv[3] | inv[2]);
    new_frame.lo  = pair_to_bin(dig[1], dig[0], inv[1] | inv[0]);
    new_frame.err = inv;
  end

  // Accept only on the edge where the count first reaches the threshold
  always_comb begin
    cnt_d = 8'd0;
    if (hex_in == s_q)
      cnt_d = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 8'd1;
    accept    = (cnt_d == STABLE_C) && (cnt_q != STABLE_C) && (s_q != snap_q);
    handshake = out_valid_q && out_ready;
  end

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    drop_d       = drop_q;
    snap_d       = snap_q;
    if (accept) begin
      snap_d = s_q;
      if (!out_valid_q) begin
        out_d       = new_frame;
        out_valid_d = 1'b1;
      end else if (handshake) begin
        if (pend_valid_q) begin
          out_d  = pend_q;
          pend_d = new_frame;
        end else begin
          out_d = new_frame;
        end
      end else begin
        pend_d       = new_frame;
        pend_valid_d = 1'b1;
        if (pend_valid_q && drop_q != 8'hFF)
          drop_d = drop_q + 8'd1;
      end
    end else if (handshake) begin
      if (pend_valid_q) begin
        out_d        = pend_q;
        pend_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK50) begin
    if (RST) begin
      s_q          <= '1;
      snap_q       <= '1;
      cnt_q        <= 8'd0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      drop_q       <= 8'd0;
    end else begin
      s_q          <= hex_in;
      snap_q       <= snap_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hi    = out_q.hi;
  assign out_lo    = out_q.lo;
  assign out_err   = out_q.err;
  assign drop_cnt  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_hexdisp_reader.sv
// ---------------------------------------------------------------------------
// tb_hexdisp_reader : directed self-checking bench for hexdisp_reader
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hexdisp_reader;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       out_valid, out_ready;
  logic [7:0] out_hi, out_lo, drop_cnt;
  logic [3:0] out_err;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  hexdisp_reader #(.STABLE_CYCLES(S)) dut (
    .CLK50     (clk),
    .RST       (rst),
    .HEX0      (hex0),
    .HEX1      (hex1),
    .HEX2      (hex2),
    .HEX3      (hex3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .out_err   (out_err),
    .drop_cnt  (drop_cnt)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000011;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
    hex3 = seg(d3); hex2 = seg(d2); hex1 = seg(d1); hex0 = seg(d0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    hex0 = 7'h7F; hex1 = 7'h7F; hex2 = 7'h7F; hex3 = 7'h7F;
    do_reset();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    if (out_hi !== 8'd0) begin failures++; $display("FAIL reset_hi got=%0d exp=0", out_hi); end
    if (out_lo !== 8'd0) begin failures++; $display("FAIL reset_lo got=%0d exp=0", out_lo); end
    if (out_err !== 4'd0) begin failures++; $display("FAIL reset_err got=%b exp=0000", out_err); end
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_single_frame();
    int seen;
    out_ready = 1'b1;
    do_reset();
    set_digits(1, 2, 5, 9);
    tick(S);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%0b exp=0", out_valid); end
    tick(1);
    checks += 4;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    if (out_hi !== 8'd12) begin failures++; $display("FAIL single_hi got=%0d exp=12", out_hi); end
    if (out_lo !== 8'd59) begin failures++; $display("FAIL single_lo got=%0d exp=59", out_lo); end
    if (out_err !== 4'd0) begin failures++; $display("FAIL single_err got=%b exp=0000", out_err); end
    seen = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", seen); end
  endtask

  task automatic test_glitch();
    int seen = 0;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_digits(3, 3, 3, i % 2);
      tick(1);
      if (out_valid === 1'b1) seen++;
      tick(1);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL glitch_valid_cycles got=%0d exp=0", seen); end
  endtask

  task automatic test_invalid_digit();
    out_ready = 1'b0;
    do_reset();
    set_digits(3, 0, 4, 7);
    hex2 = 7'b1010101;
    tick(S + 1);
    checks += 4;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL inv_valid got=%0b exp=1", out_valid); end
    if (out_err !== 4'b0100) begin failures++; $display("FAIL inv_err got=%b exp=0100", out_err); end
    if (out_hi !== 8'hFF) begin failures++; $display("FAIL inv_hi got=%0h exp=ff", out_hi); end
    if (out_lo !== 8'd47) begin failures++; $display("FAIL inv_lo got=%0d exp=47", out_lo); end
  endtask

  task automatic test_backpressure_drop();
    out_ready = 1'b0;
    do_reset();
    set_digits(0, 1, 2, 3); tick(S + 1);
    set_digits(4, 5, 6, 7); tick(S + 1);
    set_digits(8, 9, 9, 0); tick(S + 1);
    checks += 4;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", out_valid); end
    if (out_hi !== 8'd1) begin failures++; $display("FAIL bp_hold_hi got=%0d exp=1", out_hi); end
    if (out_lo !== 8'd23) begin failures++; $display("FAIL bp_hold_lo got=%0d exp=23", out_lo); end
    if (drop_cnt !== 8'd1) begin failures++; $display("FAIL bp_drop got=%0d exp=1", drop_cnt); end
    out_ready = 1'b1;
    tick(1);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%0b exp=1", out_valid); end
    if (out_hi !== 8'd89) begin failures++; $display("FAIL bp_next_hi got=%0d exp=89", out_hi); end
    if (out_lo !== 8'd90) begin failures++; $display("FAIL bp_next_lo got=%0d exp=90", out_lo); end
    tick(1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_fall got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    do_reset();
    set_digits(0, 1, 2, 3); tick(S + 1);
    set_digits(4, 5, 6, 7); tick(S + 1);
    set_digits(2, 3, 5, 8);
    tick(S);
    out_ready = 1'b1;
    tick(1);
    checks += 3;
    if (out_hi !== 8'd45) begin failures++; $display("FAIL b2b_hi got=%0d exp=45", out_hi); end
    if (out_lo !== 8'd67) begin failures++; $display("FAIL b2b_lo got=%0d exp=67", out_lo); end
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL b2b_drop got=%0d exp=0", drop_cnt); end
    tick(1);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_pend_valid got=%0b exp=1", out_valid); end
    if (out_hi !== 8'd23) begin failures++; $display("FAIL b2b_pend_hi got=%0d exp=23", out_hi); end
    if (out_lo !== 8'd58) begin failures++; $display("FAIL b2b_pend_lo got=%0d exp=58", out_lo); end
    tick(1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_fall got=%0b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    out_ready = 1'b0;
    do_reset();
    set_digits(0, 1, 2, 3); tick(S + 1);
    set_digits(4, 5, 6, 7); tick(S + 1);
    rst = 1'b1;
    hex0 = 7'h7F; hex1 = 7'h7F; hex2 = 7'h7F; hex3 = 7'h7F;
    tick(1);
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%0b exp=0", out_valid); end
    if (out_hi !== 8'd0) begin failures++; $display("FAIL mrst_hi got=%0d exp=0", out_hi); end
    if (out_lo !== 8'd0) begin failures++; $display("FAIL mrst_lo got=%0d exp=0", out_lo); end
    if (out_err !== 4'd0) begin failures++; $display("FAIL mrst_err got=%b exp=0000", out_err); end
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL mrst_drop got=%0d exp=0", drop_cnt); end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL mrst_blank_frames got=%0d exp=0", seen); end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    hex0 = 7'h7F; hex1 = 7'h7F; hex2 = 7'h7F; hex3 = 7'h7F;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_invalid_digit();
    test_backpressure_drop();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hexdisp_reader.md
# hexdisp_reader

Receive-side counterpart of the alarm clock's BCD-to-seven-segment display path. Samples the four active-low HEX segment buses and waits for the display to settle. It then decodes each settled frame back to digits and presents the two-digit pairs as binary values on a valid/ready output. Used as an in-fabric display monitor and as the self-check end of the clock/alarm display chain.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a frame is accepted; legal range 1..255.
- CLK50  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- HEX0, HEX1, HEX2, HEX3  in  7 each  active-low segments {g,f,e,d,c,b,a}. HEX3 is the most significant digit.
- out_valid  out  1  a decoded frame is held on the outputs.
- out_ready  in  1  consumer accepts the frame in any cycle where out_valid && out_ready.
- out_hi  out  8  10*d3 + d2, range 0..99; 8'hFF if d3 or d2 is invalid.
- out_lo  out  8  10*d1 + d0, range 0..99; 8'hFF if d1 or d0 is invalid.
- out_err  out  4  per-digit invalid-pattern mask; bit i corresponds to HEXi.
- drop_cnt  out  8  saturating count of frames overwritten before delivery.

## Operation
- Digit table (exact match required):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000011, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other pattern is invalid: digit 4'hF, err bit set.
- Sample register `s` (28 bits) loads {HEX3..HEX0} every edge.
- Stability counter `cnt` (8 bits):
  - cleared when the incoming frame ≠ `s`;
  - otherwise increments, saturating at STABLE_CYCLES.
- Accept event: fires in the cycle `cnt` reaches STABLE_CYCLES, but only when `s` ≠ the last-accepted snapshot `snap`. On accept, `snap` is loaded with `s`. A frame held stable is accepted at most once.
- Decoded frame = {out_hi, out_lo, out_err}, computed from `s` at accept time.
- Delivery uses the output register plus a one-entry pending slot. Cases on an accept:
  - Output empty (out_valid = 0): load output; out_valid = 1.
  - Output full, handshake this cycle, pending empty: load output with the new frame.
  - Output full, handshake this cycle, pending full: output takes the pending frame; the new frame goes to pending; no drop.
  - Output full, no handshake, pending empty: new frame goes to pending.
  - Output full, no handshake, pending full: pending is overwritten; drop_cnt increments, saturating at 255.
- Handshake with no accept in the same cycle:
  - pending full: output takes pending; out_valid stays 1; pending is cleared.
  - pending empty: out_valid = 0.
- Reset values:
  - out_valid 0, out_hi 0, out_lo 0, out_err 0, drop_cnt 0
  - pending empty, `cnt` 0
  - `s` and `snap` all-ones (a blank display)
- Effect of the blank reset value: a display that stays blank after reset is never accepted.
- RST asserted mid-operation discards the output and pending frames in the same edge. No partial frame survives.

## Timing
- A frame applied constantly from edge k is sampled at edge k. It is accepted at edge k+STABLE_CYCLES, and out_valid is high from that edge when the output is free.
- A frame change before STABLE_CYCLES restarts the count; glitches shorter than STABLE_CYCLES edges produce no output.
- Outputs are registered; there is no combinational path from HEX* or out_ready to any output.
- out_hi, out_lo and out_err are stable while out_valid && !out_ready.
- One frame per handshake; maximum throughput is one frame per STABLE_CYCLES+1 cycles.

## Structure
- Shared package `seg7_pkg` holds:
  - the ten digit pattern constants, SEG_BLANK = 7'h7F, DIG_INVALID = 4'hF
  - a `seg_frame_t` 28-bit typedef
  - these constants are shared with the display encoder.
- Sub-module `seg7_to_bcd`: combinational pattern → {digit[3:0], invalid}. Instantiated four times on `s`.
- Pair conversion (10*dh + dl) and the 0xFF substitution live in the top level.

## Test plan
- Reset, then hold HEX3..0 = 1, 2, 5, 9 with out_ready = 1 → out_valid at edge STABLE_CYCLES; out_hi = 12, out_lo = 59, out_err = 0; exactly one frame delivered.
- Toggle HEX0 between 0 and 1 every 2 cycles (STABLE_CYCLES = 4) for 40 cycles → no frame; out_valid stays 0.
- HEX2 = 7'b1010101 with the other digits valid, all stable → out_err = 4'b0100, out_hi = 8'hFF, out_lo decoded normally.
- out_ready = 0; deliver three distinct stable frames A, B, C → output holds A, pending holds C, drop_cnt = 1. Raise out_ready → C is delivered next cycle, then out_valid falls.
- Handshake and accept in the same cycle with pending full → output = old pending, pending = new frame, drop_cnt unchanged.
- Assert RST for one cycle while out_valid = 1 and pending is full → all outputs reach their reset values the next cycle. An all-blank display afterwards yields no frame.
